// File: rtl/mem_arbiter_if.sv
// Request, response and memory buses around the data-memory arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [1:0]        ls_size;
    logic              ls_unsigned;
    logic [31:0]       ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [31:0]       ls_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_bmask;
    logic              mem_wren;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_size,
        input  ls_unsigned, ls_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_addr, mem_wdata, mem_bmask, mem_wren
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_size,
        output ls_unsigned, ls_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_addr, mem_wdata, mem_bmask, mem_wren
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin IF/LS arbiter for the shared data memory; splits misaligned
// LS accesses into two word beats and returns registered, extended loads.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic {IDLE, SPLIT} state_t;

    state_t            state, state_nx;
    logic              last_ls;
    logic              if_sel, ls_sel;
    logic [1:0]        off;
    logic [7:0]        mask_base, mask8;
    logic [63:0]       data64;
    logic              split;
    logic [ADDR_W-1:0] word_a;

    logic [ADDR_W-1:0] s_addr;
    logic [3:0]        s_mask;
    logic [31:0]       s_data;
    logic [1:0]        s_size;
    logic              s_uns;
    logic              s_we;
    logic [1:0]        s_off;
    logic [31:0]       s_word;

    function automatic logic [31:0] extract(
        input logic [63:0] raw,
        input logic [1:0]  sh,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [63:0] v;
        v = raw >> {sh, 3'b000};
        unique case (size)
            2'b00:   return {{24{~uns & v[7]}}, v[7:0]};
            2'b01:   return {{16{~uns & v[15]}}, v[15:0]};
            default: return v[31:0];
        endcase
    endfunction

    always_comb begin
        off = bus.ls_addr[1:0];
        unique case (bus.ls_size)
            2'b00:   mask_base = 8'h01;
            2'b01:   mask_base = 8'h03;
            default: mask_base = 8'h0f;
        endcase
        mask8  = mask_base << off;
        data64 = {32'h0, bus.ls_wdata} << {off, 3'b000};
        split  = |mask8[7:4];
        word_a = bus.ls_addr >> 2;

        // Round robin: on contention the port not granted last wins.
        if_sel = 1'b0;
        ls_sel = 1'b0;
        if (state == IDLE && !i_reset) begin
            if_sel = bus.if_req && (!bus.ls_req || last_ls);
            ls_sel = bus.ls_req && !if_sel;
        end

        state_nx      = state;
        bus.if_gnt    = if_sel;
        bus.ls_gnt    = ls_sel;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_bmask = '0;
        bus.mem_wren  = 1'b0;

        if (state == SPLIT) begin
            bus.mem_addr  = s_addr;
            bus.mem_wdata = s_data;
            bus.mem_bmask = s_we ? s_mask : 4'b0000;
            bus.mem_wren  = s_we;
            state_nx      = IDLE;
        end else if (if_sel) begin
            bus.mem_addr = bus.if_addr >> 2;
        end else if (ls_sel) begin
            bus.mem_addr  = word_a;
            bus.mem_wdata = data64[31:0];
            bus.mem_bmask = bus.ls_we ? mask8[3:0] : 4'b0000;
            bus.mem_wren  = bus.ls_we;
            if (split) state_nx = SPLIT;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            last_ls       <= 1'b1;
            bus.if_rvalid <= 1'b0;
            bus.if_rdata  <= '0;
            bus.ls_rvalid <= 1'b0;
            bus.ls_rdata  <= '0;
            s_addr        <= '0;
            s_mask        <= '0;
            s_data        <= '0;
            s_size        <= '0;
            s_uns         <= 1'b0;
            s_we          <= 1'b0;
            s_off         <= '0;
            s_word        <= '0;
        end else begin
            state         <= state_nx;
            bus.if_rvalid <= if_sel;
            bus.ls_rvalid <= 1'b0;
            if (if_sel) begin
                last_ls      <= 1'b0;
                bus.if_rdata <= bus.mem_rdata;
            end
            if (ls_sel) begin
                last_ls <= 1'b1;
                if (split) begin
                    s_addr <= word_a + ADDR_W'(1);
                    s_mask <= mask8[7:4];
                    s_data <= data64[63:32];
                    s_size <= bus.ls_size;
                    s_uns  <= bus.ls_unsigned;
                    s_we   <= bus.ls_we;
                    s_off  <= off;
                    s_word <= bus.mem_rdata;
                end else begin
                    bus.ls_rvalid <= 1'b1;
                    bus.ls_rdata  <= bus.ls_we ? 32'h0 :
                        extract({32'h0, bus.mem_rdata}, off,
                                bus.ls_size, bus.ls_unsigned);
                end
            end
            if (state == SPLIT) begin
                bus.ls_rvalid <= 1'b1;
                bus.ls_rdata  <= s_we ? 32'h0 :
                    extract({bus.mem_rdata, s_word}, s_off, s_size, s_uns);
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run
// against a byte-level memory model.
module tb_mem_arbiter;
    logic i_clk;
    logic i_reset;
    int   checks;
    int   failures;

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [31:0] mem [0:63];
    logic        init_we;
    logic [5:0]  init_idx;
    logic [31:0] init_val;
    logic [7:0]  ref_mem [0:255];

    assign bus.mem_rdata = mem[bus.mem_addr[5:0]];

    always @(posedge i_clk) begin
        if (init_we)
            mem[init_idx] <= init_val;
        else if (bus.mem_wren)
            for (int b = 0; b < 4; b++)
                if (bus.mem_bmask[b])
                    mem[bus.mem_addr[5:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req      = 1'b0;
        bus.if_addr     = '0;
        bus.ls_req      = 1'b0;
        bus.ls_we       = 1'b0;
        bus.ls_addr     = '0;
        bus.ls_size     = 2'b00;
        bus.ls_unsigned = 1'b0;
        bus.ls_wdata    = '0;
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        init_we  = 1'b1;
        init_idx = 6'(idx);
        init_val = val;
        tick();
        init_we  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a,
                                             input int n,
                                             input logic uns);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++)
            v = v | (32'(ref_mem[8'(a + 32'(i))]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1])
            v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic test_reset();
        idle_inputs();
        i_reset = 1'b1;
        tick();
        bus.if_req = 1'b1;
        bus.ls_req = 1'b1;
        bus.ls_we  = 1'b1;
        #2;
        checks++;
        if (bus.if_gnt !== 1'b0 || bus.ls_gnt !== 1'b0) begin
            failures++;
            $display("FAIL reset_gnt got if=%b ls=%b exp 0 0", bus.if_gnt, bus.ls_gnt);
        end
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wren !== 1'b0 || bus.mem_bmask !== 4'h0) begin
            failures++;
            $display("FAIL reset_mem got addr=%h wren=%b bmask=%b exp 0 0 0",
                     bus.mem_addr, bus.mem_wren, bus.mem_bmask);
        end
        checks++;
        if (bus.if_rvalid !== 1'b0 || bus.ls_rvalid !== 1'b0 ||
            bus.if_rdata !== 32'h0 || bus.ls_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_resp got %b %b %h %h exp 0 0 0 0",
                     bus.if_rvalid, bus.ls_rvalid, bus.if_rdata, bus.ls_rdata);
        end
        idle_inputs();
        tick();
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_if_stream();
        logic [31:0] vals [3];
        for (int k = 0; k < 3; k++) begin
            vals[k] = $urandom;
            poke(k, vals[k]);
        end
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bus.if_req  = 1'b1;
            bus.if_addr = 32'(4 * k) | 32'(k);
            #2;
            checks++;
            if (bus.if_gnt !== 1'b1 || bus.ls_gnt !== 1'b0 || bus.mem_addr !== 32'(k)) begin
                failures++;
                $display("FAIL if_stream_gnt k=%0d got gnt=%b addr=%h exp 1 %h",
                         k, bus.if_gnt, bus.mem_addr, k);
            end
            tick();
            checks++;
            if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== vals[k]) begin
                failures++;
                $display("FAIL if_stream_data k=%0d got v=%b d=%h exp 1 %h",
                         k, bus.if_rvalid, bus.if_rdata, vals[k]);
            end
            checks++;
            if (bus.ls_rvalid !== 1'b0 || bus.ls_rdata !== 32'h0) begin
                failures++;
                $display("FAIL if_stream_ls got v=%b d=%h exp 0 0", bus.ls_rvalid, bus.ls_rdata);
            end
        end
        idle_inputs();
        tick();
        checks++;
        if (bus.if_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL if_stream_end got rvalid=%b exp 0", bus.if_rvalid);
        end
    endtask

    task automatic test_alternation();
        logic exp_if;
        do_reset();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h20;
        bus.ls_req  = 1'b1;
        bus.ls_addr = 32'h40;
        bus.ls_size = 2'b10;
        for (int c = 0; c < 6; c++) begin
            exp_if = (c % 2 == 0);
            #2;
            checks++;
            if (bus.if_gnt !== exp_if || bus.ls_gnt !== !exp_if ||
                bus.mem_addr !== (exp_if ? 32'd8 : 32'd16)) begin
                failures++;
                $display("FAIL alternate c=%0d got if=%b ls=%b addr=%h exp if=%b",
                         c, bus.if_gnt, bus.ls_gnt, bus.mem_addr, exp_if);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_byte_store_load();
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b1;
        bus.ls_addr  = 32'h5;
        bus.ls_size  = 2'b00;
        bus.ls_wdata = 32'hAB;
        #2;
        checks++;
        if (bus.ls_gnt !== 1'b1 || bus.mem_addr !== 32'h1 || bus.mem_bmask !== 4'b0010 ||
            bus.mem_wdata !== 32'h0000AB00 || bus.mem_wren !== 1'b1) begin
            failures++;
            $display("FAIL byte_store got gnt=%b a=%h m=%b d=%h w=%b exp 1 1 0010 0000ab00 1",
                     bus.ls_gnt, bus.mem_addr, bus.mem_bmask, bus.mem_wdata, bus.mem_wren);
        end
        tick();
        checks++;
        if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'h0) begin
            failures++;
            $display("FAIL byte_store_done got v=%b d=%h exp 1 0", bus.ls_rvalid, bus.ls_rdata);
        end
        bus.ls_we    = 1'b0;
        bus.ls_wdata = 32'hFFFF_FFFF;
        #2;
        checks++;
        if (bus.mem_wren !== 1'b0 || bus.mem_bmask !== 4'b0000) begin
            failures++;
            $display("FAIL byte_load_bus got w=%b m=%b exp 0 0000", bus.mem_wren, bus.mem_bmask);
        end
        tick();
        bus.ls_unsigned = 1'b1;
        checks++;
        if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'hFFFFFFAB) begin
            failures++;
            $display("FAIL byte_load_signed got v=%b d=%h exp 1 ffffffab", bus.ls_rvalid, bus.ls_rdata);
        end
        tick();
        idle_inputs();
        checks++;
        if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'h000000AB) begin
            failures++;
            $display("FAIL byte_load_unsigned got v=%b d=%h exp 1 000000ab", bus.ls_rvalid, bus.ls_rdata);
        end
        tick();
    endtask

    task automatic test_split_store_load();
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b1;
        bus.ls_addr  = 32'h6;
        bus.ls_size  = 2'b10;
        bus.ls_wdata = 32'h11223344;
        #2;
        checks++;
        if (bus.ls_gnt !== 1'b1 || bus.mem_addr !== 32'h1 || bus.mem_bmask !== 4'b1100 ||
            bus.mem_wdata !== 32'h33440000 || bus.mem_wren !== 1'b1) begin
            failures++;
            $display("FAIL split_beat1 got gnt=%b a=%h m=%b d=%h w=%b exp 1 1 1100 33440000 1",
                     bus.ls_gnt, bus.mem_addr, bus.mem_bmask, bus.mem_wdata, bus.mem_wren);
        end
        tick();
        bus.ls_req   = 1'b0;
        bus.ls_addr  = 32'h30;
        bus.ls_wdata = 32'h0;
        #2;
        checks++;
        if (bus.ls_gnt !== 1'b0 || bus.ls_rvalid !== 1'b0 || bus.mem_addr !== 32'h2 ||
            bus.mem_bmask !== 4'b0011 || bus.mem_wdata !== 32'h00001122 || bus.mem_wren !== 1'b1) begin
            failures++;
            $display("FAIL split_beat2 got gnt=%b v=%b a=%h m=%b d=%h w=%b exp 0 0 2 0011 00001122 1",
                     bus.ls_gnt, bus.ls_rvalid, bus.mem_addr, bus.mem_bmask, bus.mem_wdata, bus.mem_wren);
        end
        tick();
        checks++;
        if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'h0 ||
            mem[1][31:16] !== 16'h3344 || mem[2][15:0] !== 16'h1122) begin
            failures++;
            $display("FAIL split_store_mem got v=%b m1=%h m2=%h exp 1 3344xxxx xxxx1122",
                     bus.ls_rvalid, mem[1], mem[2]);
        end
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_addr = 32'h6;
        #2;
        checks++;
        if (bus.ls_gnt !== 1'b1) begin
            failures++;
            $display("FAIL split_load_gnt got %b exp 1", bus.ls_gnt);
        end
        tick();
        bus.ls_req  = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0;
        #2;
        checks++;
        if (bus.if_gnt !== 1'b0 || bus.ls_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL split_hold_if got gnt=%b rvalid=%b exp 0 0", bus.if_gnt, bus.ls_rvalid);
        end
        tick();
        checks++;
        if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'h11223344) begin
            failures++;
            $display("FAIL split_load got v=%b d=%h exp 1 11223344", bus.ls_rvalid, bus.ls_rdata);
        end
        #2;
        checks++;
        if (bus.if_gnt !== 1'b1) begin
            failures++;
            $display("FAIL split_if_after got gnt=%b exp 1", bus.if_gnt);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_half_load();
        poke(1, 32'h80000000);
        poke(2, 32'h000000FF);
        bus.ls_req  = 1'b1;
        bus.ls_addr = 32'h7;
        bus.ls_size = 2'b01;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'hFFFFFF80) begin
            failures++;
            $display("FAIL half_split_load got v=%b d=%h exp 1 ffffff80", bus.ls_rvalid, bus.ls_rdata);
        end
        tick();
    endtask

    task automatic test_reset_split();
        poke(3, 32'h0);
        poke(4, 32'hCAFEF00D);
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b1;
        bus.ls_addr  = 32'hE;
        bus.ls_size  = 2'b10;
        bus.ls_wdata = 32'hDEADBEEF;
        tick();
        idle_inputs();
        i_reset = 1'b1;
        #2;
        checks++;
        if (bus.mem_wren !== 1'b0) begin
            failures++;
            $display("FAIL reset_split_wren got %b exp 0", bus.mem_wren);
        end
        tick();
        i_reset = 1'b0;
        tick();
        checks++;
        if (bus.ls_rvalid !== 1'b0 || mem[4] !== 32'hCAFEF00D || mem[3] !== 32'hBEEF0000) begin
            failures++;
            $display("FAIL reset_split got v=%b m3=%h m4=%h exp 0 beef0000 cafef00d",
                     bus.ls_rvalid, mem[3], mem[4]);
        end
    endtask

    task automatic test_random();
        logic [31:0] w, if_exp, ls_exp, ea;
        int          if_due, ls_due, n, off, bad;
        logic        last_ls, busy, g_if, g_ls, sp;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            poke(i, w);
            for (int b = 0; b < 4; b++) ref_mem[4*i+b] = w[8*b +: 8];
        end
        do_reset();
        last_ls = 1'b1;
        busy    = 1'b0;
        if_due  = -1;
        ls_due  = -1;
        if_exp  = '0;
        ls_exp  = '0;
        for (int c = 0; c < 500; c++) begin
            checks++;
            if (bus.if_rvalid !== (if_due == c) ||
                (if_due == c && bus.if_rdata !== if_exp)) begin
                failures++;
                $display("FAIL rand_if c=%0d got v=%b d=%h exp v=%b d=%h",
                         c, bus.if_rvalid, bus.if_rdata, if_due == c, if_exp);
            end
            checks++;
            if (bus.ls_rvalid !== (ls_due == c) ||
                (ls_due == c && bus.ls_rdata !== ls_exp)) begin
                failures++;
                $display("FAIL rand_ls c=%0d got v=%b d=%h exp v=%b d=%h",
                         c, bus.ls_rvalid, bus.ls_rdata, ls_due == c, ls_exp);
            end
            bus.if_req      = (c < 496) && ($urandom_range(0, 3) != 0);
            bus.if_addr     = $urandom;
            bus.ls_req      = (c < 496) && ($urandom_range(0, 2) != 0);
            bus.ls_we       = $urandom_range(0, 1) == 1;
            bus.ls_addr     = $urandom;
            bus.ls_size     = 2'($urandom_range(0, 3));
            bus.ls_unsigned = $urandom_range(0, 1) == 1;
            bus.ls_wdata    = $urandom;
            #2;
            if (busy) begin
                g_if = 1'b0;
                g_ls = 1'b0;
                busy = 1'b0;
            end else begin
                g_if = (bus.if_req && bus.ls_req) ? last_ls : bus.if_req;
                g_ls = bus.ls_req && !g_if;
            end
            checks++;
            if (bus.if_gnt !== g_if || bus.ls_gnt !== g_ls) begin
                failures++;
                $display("FAIL rand_gnt c=%0d got if=%b ls=%b exp if=%b ls=%b",
                         c, bus.if_gnt, bus.ls_gnt, g_if, g_ls);
            end
            if (g_if) begin
                ea      = bus.if_addr & ~32'h3;
                if_exp  = ref_load(ea, 4, 1'b1);
                if_due  = c + 1;
                last_ls = 1'b0;
                checks++;
                if (bus.mem_addr !== (bus.if_addr >> 2)) begin
                    failures++;
                    $display("FAIL rand_if_addr got %h exp %h", bus.mem_addr, bus.if_addr >> 2);
                end
            end
            if (g_ls) begin
                n   = (bus.ls_size == 2'b00) ? 1 : (bus.ls_size == 2'b01) ? 2 : 4;
                off = int'(bus.ls_addr % 4);
                sp  = (off + n) > 4;
                checks++;
                if (bus.mem_addr !== (bus.ls_addr / 4)) begin
                    failures++;
                    $display("FAIL rand_ls_addr got %h exp %h", bus.mem_addr, bus.ls_addr / 4);
                end
                if (bus.ls_we) begin
                    for (int i = 0; i < n; i++)
                        ref_mem[8'(bus.ls_addr + 32'(i))] = bus.ls_wdata[8*i +: 8];
                    ls_exp = '0;
                end else begin
                    ls_exp = ref_load(bus.ls_addr, n, bus.ls_unsigned);
                end
                ls_due  = c + (sp ? 2 : 1);
                busy    = sp;
                last_ls = 1'b1;
            end
            tick();
        end
        idle_inputs();
        bad = -1;
        for (int i = 0; i < 64; i++) begin
            w = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
            if (mem[i] !== w && bad < 0) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL rand_mem_image word=%0d got %h exp %h", bad, mem[bad],
                     {ref_mem[4*bad+3], ref_mem[4*bad+2], ref_mem[4*bad+1], ref_mem[4*bad]});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        init_we  = 1'b0;
        init_idx = '0;
        init_val = '0;
        i_reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_if_stream();
        test_alternation();
        test_byte_store_load();
        test_split_store_load();
        test_half_load();
        test_reset_split();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer that shares the single-port, byte-masked, combinational-read data memory between the instruction-fetch (IF) port and the load/store (LS) port of the core. It accepts at most one request per cycle with round-robin fairness. It splits misaligned LS accesses into two word beats, and returns registered, size-extracted and sign/zero-extended load data. It sits between the pipeline front-end/LSU and the memory instance.

## Interface
- ADDR_W, 32, byte-address width of both request ports; memory word index is ADDR_W bits wide
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  reset i_reset, asynchronous, active-high; clock i_clk
- i_if_req  in  1  fetch request
- i_if_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
- o_if_gnt  out  1  fetch accepted this cycle (combinational)
- o_if_rvalid  out  1  fetch data valid (registered pulse)
- o_if_rdata  out  32  fetched word; holds until next o_if_rvalid
- i_ls_req  in  1  load/store request
- i_ls_we  in  1  1 = store, 0 = load
- i_ls_addr  in  ADDR_W  byte address, any alignment
- i_ls_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- i_ls_unsigned  in  1  zero-extend load result
- i_ls_wdata  in  32  store data, LSB-justified
- o_ls_gnt  out  1  LS accepted this cycle (combinational)
- o_ls_rvalid  out  1  LS completion pulse for loads and stores
- o_ls_rdata  out  32  extended load data; 0 on store completion
- o_mem_addr  out  ADDR_W  memory word index
- o_mem_wdata  out  32  memory write data
- o_mem_bmask  out  4  memory byte enables
- o_mem_wren  out  1  memory write enable
- i_mem_rdata  in  32  memory read data, combinational on o_mem_addr

## Operation
- FSM states: IDLE and SPLIT.
- IDLE arbitration:
  - Only one port requesting: that port is granted.
  - Both requesting: the port not granted last is granted.
  - Register last_gnt updates on every grant.
  - No request: o_mem_addr=0, o_mem_wren=0, o_mem_bmask=0.
- IF grant: o_mem_addr=i_if_addr[ADDR_W-1:2], wren=0. i_mem_rdata is registered into o_if_rdata. o_if_rvalid=1 next cycle.
- LS access geometry:
  - off = addr[1:0]; n = 1/2/4 bytes by size.
  - 8-bit mask m = ((1<<n)-1)<<off; 64-bit data d = i_ls_wdata<<(8*off).
  - Beat 1 uses word A=addr>>2, m[3:0], d[31:0].
  - Split when off+n>4, i.e. m[7:4]≠0.
- LS grant, not split:
  - Single beat; wren=i_ls_we, bmask=m[3:0] (loads drive bmask=0).
  - Load: result = i_mem_rdata>>(8*off), truncated to n bytes, sign-extended unless i_ls_unsigned.
  - o_ls_rvalid next cycle.
- LS grant, split:
  - Beat 1 issued in the grant cycle. Latch A+1 (wraps modulo 2^ADDR_W), m[7:4], d[63:32], size, unsigned flag, off, we, and the beat-1 read word. Go to SPLIT.
  - SPLIT: issue beat 2 from the latched values; no grants to either port; return to IDLE.
  - Load result = ({beat2_word, beat1_word}>>(8*off)) truncated and extended as above.
  - o_ls_rvalid the cycle after beat 2.
- After a grant the requester may change its inputs; the arbiter uses only latched values afterwards.
- A port may request again in its own rvalid cycle (back-to-back pipelining).

## Timing
- Reset values:
  - State IDLE; last_gnt=LS, so IF wins the first contention.
  - o_if_rvalid=0, o_ls_rvalid=0, o_if_rdata=0, o_ls_rdata=0.
  - o_*_gnt=0 and memory outputs idle (addr 0, wren 0, bmask 0).
- Aligned latency: gnt in cycle N, rvalid in N+1.
- Split latency: gnt in N, beat 2 in N+1, rvalid in N+2; both grants are 0 in N+1.
- Store write occurs at the rising edge closing each beat cycle.
- Sustained throughput is 1 access/cycle when no splits occur.
- Both ports requesting continuously: grants alternate strictly. A split counts as one LS grant.
- Reset asserted during SPLIT:
  - Beat 2 is abandoned and no rvalid is produced.
  - A beat-1 store write already committed stays in memory.
- rvalid and rdata are registered only; no combinational path from i_mem_rdata to outputs.

## Test plan
- Reset, then IF-only stream at addrs 0x0, 0x4, 0x8: gnt every cycle; rvalid N+1 with mem[0], mem[1], mem[2]; LS outputs stay 0.
- Both ports requesting for 6 cycles after reset: grants IF, LS, IF, LS, IF, LS; o_mem_addr alternates accordingly.
- Byte store 0xAB to addr 0x5, then load size=00 signed from 0x5: bmask=0010, wdata=0x0000AB00; load returns 0xFFFFFFAB; unsigned load returns 0x000000AB.
- Word store 0x11223344 to addr 0x6:
  - beat 1: word 1, bmask 1100, wdata 0x33440000;
  - beat 2: word 2, bmask 0011, wdata 0x00001122.
  - A word load from 0x6 returns 0x11223344 with rvalid at N+2; an IF request held during beat 2 gets no gnt.
- Half load signed from 0x7 with mem[1]=0x80000000, mem[2]=0x000000FF: result 0xFFFFFF80 (bytes 0x80 then 0xFF).
- Reset asserted in the SPLIT cycle of a word store at 0xE: no o_ls_rvalid; mem[4] unchanged; mem[3] bytes 2-3 written.
